command_frame_controller: RTL and testbench

COMMAND_FRAME_CONTROLLER -- requirements
Module: command_frame_controller

---
 rtl/command_frame_controller.sv | 274 +++++++++++++++++++++++++++
 tb/tb_command_frame_controller.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/command_frame_controller.sv
// Byte-stream command frame controller: decodes rx frames into register-file
// writes/reads and ALU jobs, then returns read data or ALU results over tx.
module command_frame_controller #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int RESULT_BYTES   = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               rx_data_valid,
  input  logic [DATA_WIDTH-1:0]              rx_data,
  input  logic                               tx_busy,
  output logic                               tx_data_valid,
  output logic [DATA_WIDTH-1:0]              tx_data,
  output logic [ADDR_WIDTH-1:0]              rf_address,
  output logic                               rf_write_en,
  output logic [DATA_WIDTH-1:0]              rf_write_data,
  output logic                               rf_read_en,
  input  logic                               rf_read_data_valid,
  input  logic [DATA_WIDTH-1:0]              rf_read_data,
  output logic [3:0]                         alu_function,
  output logic                               alu_en,
  output logic                               alu_clk_en,
  input  logic                               alu_result_valid,
  input  logic [RESULT_BYTES*DATA_WIDTH-1:0] alu_result,
  output logic                               timeout_error,
  output logic                               unknown_cmd,
  output logic                               busy
);
  localparam int RES_W = RESULT_BYTES * DATA_WIDTH;
  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int CNT_W = $clog2(RESULT_BYTES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    WR_ADDR  = 4'd1,
    WR_DATA  = 4'd2,
    RD_ADDR  = 4'd3,
    RD_WAIT  = 4'd4,
    ALU_A    = 4'd5,
    ALU_B    = 4'd6,
    ALU_FN   = 4'd7,
    ALU_WAIT = 4'd8,
    TX_LOAD  = 4'd9,
    TX_HOLD  = 4'd10
  } state_t;

  // Command bytes occupy the low 8 bits; wider buses require zero upper bits.
  function automatic logic is_cmd(input logic [DATA_WIDTH-1:0] b, input logic [7:0] code);
    is_cmd = (b == DATA_WIDTH'(code));
  endfunction

  function automatic logic is_timed(input state_t s);
    case (s)
      WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_A, ALU_B, ALU_FN, ALU_WAIT: is_timed = 1'b1;
      default: is_timed = 1'b0;
    endcase
  endfunction

  state_t            state_r, state_nxt_s;
  logic              tx_data_valid_r, tx_data_valid_nxt_s;
  logic [DATA_WIDTH-1:0] tx_data_r, tx_data_nxt_s;
  logic [ADDR_WIDTH-1:0] rf_address_r, rf_address_nxt_s;
  logic              rf_write_en_r, rf_write_en_nxt_s;
  logic [DATA_WIDTH-1:0] rf_write_data_r, rf_write_data_nxt_s;
  logic              rf_read_en_r, rf_read_en_nxt_s;
  logic [3:0]        alu_function_r, alu_function_nxt_s;
  logic              alu_en_r, alu_en_nxt_s;
  logic              alu_clk_en_r, alu_clk_en_nxt_s;
  logic              timeout_error_r, timeout_error_nxt_s;
  logic              unknown_cmd_r, unknown_cmd_nxt_s;
  logic              busy_r, busy_nxt_s;
  logic [RES_W-1:0]  result_r, result_nxt_s;
  logic [CNT_W-1:0]  left_r, left_nxt_s;
  logic [TO_W-1:0]   timer_r, timer_nxt_s;
  logic              expire_s;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode and next values of every registered output.
  always_comb begin
    state_nxt_s         = state_r;
    tx_data_valid_nxt_s = 1'b0;
    tx_data_nxt_s       = tx_data_r;
    rf_address_nxt_s    = rf_address_r;
    rf_write_en_nxt_s   = 1'b0;
    rf_write_data_nxt_s = rf_write_data_r;
    rf_read_en_nxt_s    = 1'b0;
    alu_function_nxt_s  = alu_function_r;
    alu_en_nxt_s        = 1'b0;
    timeout_error_nxt_s = 1'b0;
    unknown_cmd_nxt_s   = 1'b0;
    result_nxt_s        = result_r;
    left_nxt_s          = left_r;
    expire_s            = is_timed(state_r) && (timer_r == TO_LAST);

    if (expire_s) begin
      // Expiry beats any byte or strobe arriving in the same cycle.
      timeout_error_nxt_s = 1'b1;
      state_nxt_s         = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (rx_data_valid) begin
            if (is_cmd(rx_data, 8'hAA))      state_nxt_s = WR_ADDR;
            else if (is_cmd(rx_data, 8'hBB)) state_nxt_s = RD_ADDR;
            else if (is_cmd(rx_data, 8'hCC)) state_nxt_s = ALU_A;
            else if (is_cmd(rx_data, 8'hDD)) state_nxt_s = ALU_FN;
            else                             unknown_cmd_nxt_s = 1'b1;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        WR_ADDR: begin
          if (rx_data_valid) begin
            rf_address_nxt_s = rx_data[ADDR_WIDTH-1:0];
            state_nxt_s      = WR_DATA;
          end else begin
            state_nxt_s = WR_ADDR;
          end
        end
        WR_DATA: begin
          if (rx_data_valid) begin
            rf_write_data_nxt_s = rx_data;
            rf_write_en_nxt_s   = 1'b1;
            state_nxt_s         = IDLE;
          end else begin
            state_nxt_s = WR_DATA;
          end
        end
        RD_ADDR: begin
          if (rx_data_valid) begin
            rf_address_nxt_s = rx_data[ADDR_WIDTH-1:0];
            rf_read_en_nxt_s = 1'b1;
            state_nxt_s      = RD_WAIT;
          end else begin
            state_nxt_s = RD_ADDR;
          end
        end
        RD_WAIT: begin
          if (rf_read_data_valid) begin
            result_nxt_s        = RES_W'(rf_read_data);
            left_nxt_s          = CNT_W'(1);
            tx_data_nxt_s       = rf_read_data;
            tx_data_valid_nxt_s = 1'b1;
            state_nxt_s         = TX_LOAD;
          end else begin
            state_nxt_s = RD_WAIT;
          end
        end
        ALU_A, ALU_B: begin
          if (rx_data_valid) begin
            rf_address_nxt_s    = (state_r == ALU_A) ? ADDR_WIDTH'(0) : ADDR_WIDTH'(1);
            rf_write_data_nxt_s = rx_data;
            rf_write_en_nxt_s   = 1'b1;
            state_nxt_s         = (state_r == ALU_A) ? ALU_B : ALU_FN;
          end else begin
            state_nxt_s = state_r;
          end
        end
        ALU_FN: begin
          if (rx_data_valid) begin
            alu_function_nxt_s = rx_data[3:0];
            alu_en_nxt_s       = 1'b1;
            state_nxt_s        = ALU_WAIT;
          end else begin
            state_nxt_s = ALU_FN;
          end
        end
        ALU_WAIT: begin
          if (alu_result_valid) begin
            result_nxt_s        = alu_result;
            left_nxt_s          = CNT_W'(RESULT_BYTES);
            tx_data_nxt_s       = alu_result[DATA_WIDTH-1:0];
            tx_data_valid_nxt_s = 1'b1;
            state_nxt_s         = TX_LOAD;
          end else begin
            state_nxt_s = ALU_WAIT;
          end
        end
        TX_LOAD: begin
          if (tx_busy) begin
            // Byte accepted: pre-shift so the next LSB is ready for the hold exit.
            result_nxt_s = result_r >> DATA_WIDTH;
            left_nxt_s   = left_r - CNT_W'(1);
            state_nxt_s  = TX_HOLD;
          end else begin
            tx_data_valid_nxt_s = 1'b1;
          end
        end
        TX_HOLD: begin
          if (!tx_busy && (left_r != CNT_W'(0))) begin
            tx_data_nxt_s       = result_r[DATA_WIDTH-1:0];
            tx_data_valid_nxt_s = 1'b1;
            state_nxt_s         = TX_LOAD;
          end else if (!tx_busy) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = TX_HOLD;
          end
        end
        default: state_nxt_s = IDLE;
      endcase
    end

    if (!is_timed(state_nxt_s) || (state_nxt_s != state_r)) begin
      timer_nxt_s = {TO_W{1'b0}};
    end else begin
      timer_nxt_s = timer_r + TO_W'(1);
    end
    busy_nxt_s       = (state_nxt_s != IDLE);
    alu_clk_en_nxt_s = (state_nxt_s == ALU_FN) || (state_nxt_s == ALU_WAIT);
  end

  // Output, datapath and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_data_valid_r <= 1'b0;
      tx_data_r       <= {DATA_WIDTH{1'b0}};
      rf_address_r    <= {ADDR_WIDTH{1'b0}};
      rf_write_en_r   <= 1'b0;
      rf_write_data_r <= {DATA_WIDTH{1'b0}};
      rf_read_en_r    <= 1'b0;
      alu_function_r  <= 4'h0;
      alu_en_r        <= 1'b0;
      alu_clk_en_r    <= 1'b0;
      timeout_error_r <= 1'b0;
      unknown_cmd_r   <= 1'b0;
      busy_r          <= 1'b0;
      result_r        <= {RES_W{1'b0}};
      left_r          <= {CNT_W{1'b0}};
      timer_r         <= {TO_W{1'b0}};
    end else begin
      tx_data_valid_r <= tx_data_valid_nxt_s;
      tx_data_r       <= tx_data_nxt_s;
      rf_address_r    <= rf_address_nxt_s;
      rf_write_en_r   <= rf_write_en_nxt_s;
      rf_write_data_r <= rf_write_data_nxt_s;
      rf_read_en_r    <= rf_read_en_nxt_s;
      alu_function_r  <= alu_function_nxt_s;
      alu_en_r        <= alu_en_nxt_s;
      alu_clk_en_r    <= alu_clk_en_nxt_s;
      timeout_error_r <= timeout_error_nxt_s;
      unknown_cmd_r   <= unknown_cmd_nxt_s;
      busy_r          <= busy_nxt_s;
      result_r        <= result_nxt_s;
      left_r          <= left_nxt_s;
      timer_r         <= timer_nxt_s;
    end
  end

  assign tx_data_valid = tx_data_valid_r;
  assign tx_data       = tx_data_r;
  assign rf_address    = rf_address_r;
  assign rf_write_en   = rf_write_en_r;
  assign rf_write_data = rf_write_data_r;
  assign rf_read_en    = rf_read_en_r;
  assign alu_function  = alu_function_r;
  assign alu_en        = alu_en_r;
  assign alu_clk_en    = alu_clk_en_r;
  assign timeout_error = timeout_error_r;
  assign unknown_cmd   = unknown_cmd_r;
  assign busy          = busy_r;

endmodule

// File: tb/tb_command_frame_controller.sv
// Bench for command_frame_controller: directed frames plus random frame traffic,
// checked against a frame-level scoreboard of expected strobes and tx bytes.
module tb_command_frame_controller;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_data_valid;
  logic [7:0]  rx_data;
  logic        tx_busy;
  logic        tx_data_valid;
  logic [7:0]  tx_data;
  logic [3:0]  rf_address;
  logic        rf_write_en;
  logic [7:0]  rf_write_data;
  logic        rf_read_en;
  logic        rf_read_data_valid;
  logic [7:0]  rf_read_data;
  logic [3:0]  alu_function;
  logic        alu_en;
  logic        alu_clk_en;
  logic        alu_result_valid;
  logic [15:0] alu_result;
  logic        timeout_error;
  logic        unknown_cmd;
  logic        busy;
  logic [31:0] all_outs;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_unknown = 0, obs_unknown = 0;
  int exp_timeout = 0, obs_timeout = 0;
  logic [11:0] exp_wr[$];   // {address, data}
  logic [3:0]  exp_rd[$];
  logic [3:0]  exp_alu[$];
  logic [7:0]  exp_tx[$];

  command_frame_controller #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .RESULT_BYTES(2), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .rx_data_valid(rx_data_valid), .rx_data(rx_data),
    .tx_busy(tx_busy), .tx_data_valid(tx_data_valid), .tx_data(tx_data),
    .rf_address(rf_address), .rf_write_en(rf_write_en), .rf_write_data(rf_write_data),
    .rf_read_en(rf_read_en), .rf_read_data_valid(rf_read_data_valid), .rf_read_data(rf_read_data),
    .alu_function(alu_function), .alu_en(alu_en), .alu_clk_en(alu_clk_en),
    .alu_result_valid(alu_result_valid), .alu_result(alu_result),
    .timeout_error(timeout_error), .unknown_cmd(unknown_cmd), .busy(busy)
  );

  assign all_outs = {tx_data_valid, tx_data, rf_address, rf_write_en, rf_write_data, rf_read_en,
                     alu_function, alu_en, alu_clk_en, timeout_error, unknown_cmd, busy};

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_data_valid = 1'b1;
    @(negedge clk);
    rx_data_valid = 1'b0;
  endtask

  task automatic send_gap(input logic [7:0] b);
    idle($urandom_range(3, 0));
    send_byte(b);
  endtask

  task automatic pulse_rd(input logic [7:0] d);
    rf_read_data = d;
    rf_read_data_valid = 1'b1;
    @(negedge clk);
    rf_read_data_valid = 1'b0;
  endtask

  task automatic pulse_alu(input logic [15:0] r);
    alu_result = r;
    alu_result_valid = 1'b1;
    @(negedge clk);
    alu_result_valid = 1'b0;
  endtask

  // Transmitter model: takes n bytes, each compared against the scoreboard.
  task automatic drain_tx(input int n);
    logic [7:0] e;
    int waited;
    for (int i = 0; i < n; i++) begin
      waited = 0;
      while (!tx_data_valid && waited < 50) begin
        @(negedge clk);
        waited++;
      end
      check("tx_valid", tx_data_valid, 1'b1);
      if (!tx_data_valid) return;
      e = 8'h00;
      if (exp_tx.size() != 0) e = exp_tx.pop_front();
      check("tx_byte", tx_data, e);
      repeat ($urandom_range(2, 0)) begin
        @(negedge clk);
        check("tx_hold_valid", tx_data_valid, 1'b1);
        check("tx_hold_data", tx_data, e);
      end
      tx_busy = 1'b1;
      rx_data = 8'hAA;
      rx_data_valid = 1'b1;
      @(negedge clk);
      rx_data_valid = 1'b0;
      check("tx_drop", tx_data_valid, 1'b0);
      idle($urandom_range(2, 0));
      tx_busy = 1'b0;
      @(negedge clk);
    end
    check("tx_done_idle", busy, 1'b0);
  endtask

  // Strobe monitor: every rf/alu strobe must match the next scoreboard entry.
  initial begin
    logic [11:0] ew;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (rf_write_en) begin
          if (exp_wr.size() == 0) check("wr_spurious", rf_write_en, 1'b0);
          else begin
            ew = exp_wr.pop_front();
            check("wr_addr", rf_address, ew[11:8]);
            check("wr_data", rf_write_data, ew[7:0]);
          end
        end
        if (rf_read_en) begin
          if (exp_rd.size() == 0) check("rd_spurious", rf_read_en, 1'b0);
          else check("rd_addr", rf_address, exp_rd.pop_front());
        end
        if (alu_en) begin
          if (exp_alu.size() == 0) check("alu_spurious", alu_en, 1'b0);
          else check("alu_fn", alu_function, exp_alu.pop_front());
          check("alu_clk_at_en", alu_clk_en, 1'b1);
        end
        if (timeout_error) obs_timeout++;
        if (unknown_cmd) obs_unknown++;
      end
    end
  end

  initial begin
    int waited, seen, kind;
    logic [7:0] a, b, d;
    logic [15:0] r;
    reset = 1'b1; rx_data_valid = 1'b0; rx_data = 8'h00; tx_busy = 1'b0;
    rf_read_data_valid = 1'b0; rf_read_data = 8'h00; alu_result_valid = 1'b0; alu_result = 16'h0000;
    idle(3);
    check("reset_outs", all_outs, 32'h0);
    reset = 1'b0;
    idle(1);
    check("idle_busy", busy, 1'b0);

    // Response strobes in IDLE are ignored.
    rf_read_data_valid = 1'b1; alu_result_valid = 1'b1; alu_result = 16'h1234;
    @(negedge clk);
    rf_read_data_valid = 1'b0; alu_result_valid = 1'b0;
    check("stray_valid_tx", tx_data_valid, 1'b0);
    check("stray_valid_busy", busy, 1'b0);

    // Register write frame.
    exp_wr.push_back({4'h5, 8'h3C});
    send_byte(8'hAA); send_byte(8'h05);
    check("wr_busy", busy, 1'b1);
    send_byte(8'h3C);
    check("wr_we", rf_write_en, 1'b1);
    @(negedge clk);
    check("wr_we_pulse", rf_write_en, 1'b0);
    check("wr_idle", busy, 1'b0);

    // Register read frame.
    exp_rd.push_back(4'h7);
    exp_tx.push_back(8'h9E);
    send_byte(8'hBB); send_byte(8'h07);
    check("rd_re", rf_read_en, 1'b1);
    pulse_rd(8'h9E);
    check("rd_tx_valid", tx_data_valid, 1'b1);
    check("rd_tx_data", tx_data, 8'h9E);
    drain_tx(1);

    // Full ALU frame.
    exp_wr.push_back({4'h0, 8'h12});
    exp_wr.push_back({4'h1, 8'h34});
    exp_alu.push_back(4'h1);
    exp_tx.push_back(8'hCD); exp_tx.push_back(8'hAB);
    send_byte(8'hCC);
    check("clk_en_alu_a", alu_clk_en, 1'b0);
    send_byte(8'h12); send_byte(8'h34);
    check("clk_en_alu_fn", alu_clk_en, 1'b1);
    send_byte(8'h01);
    check("alu_en_first", alu_en, 1'b1);
    @(negedge clk);
    check("alu_en_pulse", alu_en, 1'b0);
    check("clk_en_alu_wait", alu_clk_en, 1'b1);
    pulse_alu(16'hABCD);
    check("clk_en_tx", alu_clk_en, 1'b0);
    drain_tx(2);

    // Unknown command, then a function-only ALU frame.
    send_byte(8'h55);
    exp_unknown++;
    check("unk_pulse", unknown_cmd, 1'b1);
    check("unk_idle", busy, 1'b0);
    @(negedge clk);
    check("unk_one_cycle", unknown_cmd, 1'b0);
    exp_alu.push_back(4'h3);
    exp_tx.push_back(8'h21); exp_tx.push_back(8'h43);
    send_byte(8'hDD); send_byte(8'h03);
    pulse_alu(16'h4321);
    drain_tx(2);

    // Timeout latency after last byte of an incomplete frame.
    send_byte(8'hAA); send_byte(8'h02);
    waited = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (timeout_error) begin
        waited = i;
        break;
      end
    end
    exp_timeout++;
    check("to_latency", waited, TO);
    @(negedge clk);
    check("to_one_cycle", timeout_error, 1'b0);
    check("to_idle", busy, 1'b0);

    // Last byte one cycle before expiry is accepted; a byte on the expiry cycle is dropped.
    exp_wr.push_back({4'h3, 8'h77});
    send_byte(8'hAA); send_byte(8'h03); idle(TO - 2); send_byte(8'h77);
    check("late_we", rf_write_en, 1'b1);
    check("late_no_to", timeout_error, 1'b0);
    send_byte(8'hAA); send_byte(8'h04); idle(TO - 1); send_byte(8'h66);
    exp_timeout++;
    check("expiry_to", timeout_error, 1'b1);
    check("expiry_no_we", rf_write_en, 1'b0);
    @(negedge clk);
    check("expiry_idle", busy, 1'b0);

    // Reset while the first result byte is on offer.
    exp_wr.push_back({4'h0, 8'h01});
    exp_wr.push_back({4'h1, 8'h02});
    exp_alu.push_back(4'h9);
    send_byte(8'hCC); send_byte(8'h01); send_byte(8'h02); send_byte(8'h09);
    pulse_alu(16'h5AA5);
    check("pre_reset_tx", tx_data_valid, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_reset_outs", all_outs, 32'h0);
    reset = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (tx_data_valid) seen++;
    end
    check("post_reset_no_tx", seen, 0);
    check("post_reset_idle", busy, 1'b0);

    // Random frame traffic.
    for (int f = 0; f < 60; f++) begin
      kind = $urandom_range(5, 0);
      a = 8'($urandom_range(255, 0));
      b = 8'($urandom_range(255, 0));
      d = 8'($urandom_range(255, 0));
      r = 16'($urandom_range(65535, 0));
      case (kind)
        0: begin
          exp_wr.push_back({4'(a % 16), b});
          send_gap(8'hAA); send_gap(a); send_gap(b);
        end
        1: begin
          exp_rd.push_back(4'(a % 16));
          exp_tx.push_back(d);
          send_gap(8'hBB); send_gap(a);
          idle($urandom_range(4, 0));
          pulse_rd(d);
          drain_tx(1);
        end
        2: begin
          exp_wr.push_back({4'h0, a});
          exp_wr.push_back({4'h1, b});
          exp_alu.push_back(4'(d % 16));
          exp_tx.push_back(8'(r % 256)); exp_tx.push_back(8'(r / 256));
          send_gap(8'hCC); send_gap(a); send_gap(b); send_gap(d);
          idle($urandom_range(5, 0));
          pulse_alu(r);
          drain_tx(2);
        end
        3: begin
          exp_alu.push_back(4'(d % 16));
          exp_tx.push_back(8'(r % 256)); exp_tx.push_back(8'(r / 256));
          send_gap(8'hDD); send_gap(d);
          idle($urandom_range(5, 0));
          pulse_alu(r);
          drain_tx(2);
        end
        4: begin
          while (a == 8'hAA || a == 8'hBB || a == 8'hCC || a == 8'hDD) a = a + 8'd1;
          exp_unknown++;
          send_gap(a);
        end
        default: begin
          case ($urandom_range(3, 0))
            0: send_gap(8'hAA);
            1: begin send_gap(8'hAA); send_gap(a); end
            2: begin exp_rd.push_back(4'(a % 16)); send_gap(8'hBB); send_gap(a); end
            default: begin exp_alu.push_back(4'(d % 16)); send_gap(8'hDD); send_gap(d); end
          endcase
          exp_timeout++;
          idle(TO + 2);
        end
      endcase
      idle($urandom_range(3, 0));
    end

    idle(2);
    check("unknown_count", obs_unknown, exp_unknown);
    check("timeout_count", obs_timeout, exp_timeout);
    check("wr_left", exp_wr.size(), 0);
    check("rd_left", exp_rd.size(), 0);
    check("alu_left", exp_alu.size(), 0);
    check("tx_left", exp_tx.size(), 0);
    check("final_idle", busy, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
